adder16s_arbiter: RTL and testbench
===================================

// Module: adder16s_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer sharing one sequential 16-bit adder (adder16s) among NREQ requesters.
//   - Captures the winning requester's operands and drives them to the adder.
//   - Waits the adder's fixed latency, then returns sum/carry to that requester with a one-cycle done pulse.
//   - Sits between client datapaths and the single adder16s instance.
// PARAMETERS
//   NREQ     4   number of requesters (2..8)
//   ADD_LAT  1   adder latency, in cycles, from stable operands to valid add_sum/add_cout (>=1)
// PORTS
//   clk       in   1        system clock, rising edge
//   reset     in   1        asynchronous, active-high reset
//   req       in   NREQ     level request, bit i = requester i
//   x_in      in   NREQ*16  operand x; slot i at [16i+15:16i]
//   y_in      in   NREQ*16  operand y; same packing as x_in
//   cin_in    in   NREQ     carry-in per requester
//   gnt       out  NREQ     one-hot, 1-cycle pulse: operands of slot i captured
//   done      out  NREQ     one-hot, 1-cycle pulse: sum_out/cout_out valid for slot i
//   sum_out   out  16       result, valid while done!=0, held until next done
//   cout_out  out  1        carry-out, same timing as sum_out
//   busy      out  1        1 whenever state != IDLE
//   add_x     out  16       to adder x
//   add_y     out  16       to adder y
//   add_cin   out  1        to adder cin
//   add_sum   in   16       from adder sum
//   add_cout  in   1        from adder cout
//   op_count  out  16       completed-operation count (see CONFIGURATION)
// BEHAVIOUR
//   Reset
//     - Async reset: state=IDLE, ptr=0, cnt=0.
//     - All outputs 0: gnt, done, sum_out, cout_out, busy, add_*, op_count.
//   FSM states: IDLE, WAIT, DONE.
//   IDLE
//     - If req!=0, winner = first set bit scanning ptr, ptr+1, ... mod NREQ.
//     - Register winner's x/y/cin into operand regs; gnt[winner]=1 this cycle; cnt<=0; go to WAIT.
//     - If req==0, stay in IDLE.
//   WAIT
//     - add_x/add_y/add_cin driven from operand regs, stable for the whole state.
//     - cnt increments each cycle.
//     - When cnt==ADD_LAT: register add_sum->sum_out and add_cout->cout_out; go to DONE.
//   DONE
//     - done[winner]=1 for one cycle; ptr<=(winner+1) mod NREQ; go to IDLE.
//   Timing and throughput
//     - Grant in cycle t gives done in cycle t+ADD_LAT+2.
//     - One operation per ADD_LAT+3 cycles at most.
//   Request handling
//     - req is sampled only in IDLE; req changes during WAIT/DONE are ignored.
//     - After gnt, a requester may change its operands freely.
//     - A req held high after done is re-arbitrated normally and gets lowest priority due to rotation.
//   Arithmetic
//     - Purely the adder's result: 16-bit modulo sum with carry-out.
//     - No saturation, no signed interpretation.
//   Reset mid-operation
//     - Operation aborted; no done issued; ptr returns to 0.
//   Idle operand bus
//     - add_x/add_y/add_cin keep their last values in IDLE (only reset clears them).
// CONFIGURATION
//   ARB_OPCOUNT_EN defined
//     - op_count increments by 1 on every done pulse.
//     - Wraps FFFF->0000; cleared by reset.
//   ARB_OPCOUNT_EN undefined
//     - op_count tied to 16'h0000; no counter logic.
// TESTING  (NREQ=4, ADD_LAT=1, behavioural adder16s model with 1-cycle latency)
//   1. Reset high 2 cycles, no req
//      -> all outputs 0; busy stays 0 after reset released.
//   2. req=0001, x0=100, y0=200, cin0=0
//      -> gnt=0001 at t; done=0001 at t+3; sum_out=300, cout_out=0.
//   3. Slot 1: x=FFFF, y=0001, cin=0 -> sum=0000, cout=1.
//      Then x=FFFF, y=FFFF, cin=1 -> sum=FFFF, cout=1.
//   4. req=1111 held continuously
//      -> gnt order 0,1,2,3,0; done pulses 4 cycles apart; each result matches its slot.
//   5. After slot 1 served, req=0110 simultaneously
//      -> slot 2 granted first, then slot 1.
//   6. Reset asserted during WAIT of slot 3
//      -> no done, busy=0, op_count=0; next req=1000 granted normally.
//      With ARB_OPCOUNT_EN: op_count=1 after that done.

Source files
------------

// File: rtl/adder16s_arbiter.sv
// Round-robin arbiter that time-shares one sequential 16-bit adder among NREQ requesters.
// Optional feature: define ARB_OPCOUNT_EN to count completed operations on op_count.
module adder16s_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*16-1:0] x_in,
    input  logic [NREQ*16-1:0] y_in,
    input  logic [NREQ-1:0]    cin_in,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [15:0]        sum_out,
    output logic               cout_out,
    output logic               busy,
    output logic [15:0]        add_x,
    output logic [15:0]        add_y,
    output logic               add_cin,
    input  logic [15:0]        add_sum,
    input  logic               add_cout,
    output logic [15:0]        op_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(ADD_LAT + 1) + 1;

    // Handshake: gnt[i] pulses in the cycle slot i's operands are captured (req sampled in IDLE only);
    // done[i] pulses exactly ADD_LAT+2 cycles later with sum_out/cout_out valid, no back-pressure.
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr, win, pick;
    logic          found;
    logic [CW-1:0] cnt;
    int            idx;

    // First requester at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[PW'(idx)]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        done      = '0;
        case (state)
            IDLE: begin
                if (found && !reset) begin
                    gnt[pick] = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CW'(ADD_LAT)) state_nxt = DONE;
            end
            DONE: begin
                done[win] = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            win      <= '0;
            cnt      <= '0;
            add_x    <= '0;
            add_y    <= '0;
            add_cin  <= 1'b0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    // The adder operand bus doubles as the operand register, so it holds in IDLE.
                    if (found) begin
                        win     <= pick;
                        add_x   <= x_in[16*pick +: 16];
                        add_y   <= y_in[16*pick +: 16];
                        add_cin <= cin_in[pick];
                        cnt     <= '0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ADD_LAT)) begin
                        sum_out  <= add_sum;
                        cout_out <= add_cout;
                    end
                end
                DONE: begin
                    ptr <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_OPCOUNT_EN
    logic [15:0] op_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) op_cnt_q <= '0;
        else if (state == DONE) op_cnt_q <= op_cnt_q + 16'd1;
    end

    assign op_count = op_cnt_q;
`else
    assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_adder16s_arbiter.sv
// Bench for adder16s_arbiter: random and directed requests, rotating-priority reference model,
// queue-based scoreboard checked by a free-running monitor.
module tb_adder16s_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] x_in, y_in;
    logic [3:0]  cin_in;
    logic [3:0]  gnt, done;
    logic [15:0] sum_out;
    logic        cout_out, busy;
    logic [15:0] add_x, add_y;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;
    logic [15:0] op_count;

    logic [15:0] xs[4];
    logic [15:0] ys[4];
    logic [3:0]  cins;
    logic [3:0]  hold;
    logic [3:0]  gnt_prev;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ARB_OPCOUNT_EN
    localparam bit OPC_EN = 1'b1;
`else
    localparam bit OPC_EN = 1'b0;
`endif

    assign x_in   = {xs[3], xs[2], xs[1], xs[0]};
    assign y_in   = {ys[3], ys[2], ys[1], ys[0]};
    assign cin_in = cins;

    adder16s_arbiter #(.NREQ(4), .ADD_LAT(1)) dut (
        .clk(clk), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in), .cin_in(cin_in),
        .gnt(gnt), .done(done), .sum_out(sum_out), .cout_out(cout_out), .busy(busy),
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin), .add_sum(add_sum),
        .add_cout(add_cout), .op_count(op_count)
    );

    // clock / reset / behavioural one-cycle adder
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) {add_cout, add_sum} <= 17'd0;
        else       {add_cout, add_sum} <= {1'b0, add_x} + {1'b0, add_y} + 17'(add_cin);
    end

    always @(posedge clk) gnt_prev <= gnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard + reference model
    logic [16:0] exp_q[$];
    int          slot_q[$];
    int          due_q[$];
    int          cyc = 0;
    int          ptr_m = 0;
    logic [15:0] ops_m = 0;

    function automatic logic [3:0] pick_m(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return 4'(1 << ((p + k) % 4));
        return 4'b0000;
    endfunction

    always @(negedge clk) begin
        logic        exp_busy, rst_any;
        logic [3:0]  exp_done, exp_gnt;
        logic [16:0] res;
        if (reset) begin
            rst_any = |{gnt, done, busy, sum_out, cout_out, add_x, add_y, add_cin, op_count};
            chk("reset_outputs", 32'(rst_any), 32'd0);
            exp_q.delete(); slot_q.delete(); due_q.delete();
            ptr_m = 0;
            ops_m = 0;
        end else begin
            cyc++;
            exp_busy = (exp_q.size() != 0);
            chk("busy", 32'(busy), 32'(exp_busy));
            exp_done = (exp_busy && due_q[0] == cyc) ? 4'(1 << slot_q[0]) : 4'b0000;
            chk("done", 32'(done), 32'(exp_done));
            if (exp_done != 0) begin
                chk("sum_out", 32'(sum_out), 32'(exp_q[0][15:0]));
                chk("cout_out", 32'(cout_out), 32'(exp_q[0][16]));
                chk("op_count", 32'(op_count), OPC_EN ? 32'(ops_m) : 32'd0);
                ptr_m = (slot_q[0] + 1) % 4;
                ops_m = ops_m + 16'd1;
                void'(exp_q.pop_front()); void'(slot_q.pop_front()); void'(due_q.pop_front());
            end
            exp_gnt = exp_busy ? 4'b0000 : pick_m(req, ptr_m);
            chk("gnt", 32'(gnt), 32'(exp_gnt));
            if (exp_gnt != 0) begin
                for (int s = 0; s < 4; s++) begin
                    if (exp_gnt[s]) begin
                        res = {1'b0, xs[s]} + {1'b0, ys[s]} + 17'(cins[s]);
                        exp_q.push_back(res);
                        slot_q.push_back(s);
                        due_q.push_back(cyc + 3);
                    end
                end
            end
        end
    end

    // driver tasks: clients react one cycle after their grant
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (gnt_prev[i]) begin
                xs[i]   = 16'($urandom);
                ys[i]   = 16'($urandom);
                cins[i] = 1'($urandom_range(0, 1));
                if (!hold[i]) req[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_quiet();
        logic ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (req == 0 && !busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("quiet_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        g = 4'b0000;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (gnt_prev != 0) begin
                g = gnt_prev;
                break;
            end
        end
    endtask

    task automatic run_op(input int s, input logic [15:0] x, input logic [15:0] y, input logic c);
        xs[s]   = x;
        ys[s]   = y;
        cins[s] = c;
        req[s]  = 1'b1;
        wait_quiet();
    endtask

    initial begin
        logic [3:0] g;
        reset = 1'b1;
        req   = 4'b0000;
        hold  = 4'b0000;
        cins  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            xs[i] = 16'd0;
            ys[i] = 16'd0;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) tick();

        run_op(0, 16'd100, 16'd200, 1'b0);
        chk("sum_100_200", 32'(sum_out), 32'd300);
        chk("cout_100_200", 32'(cout_out), 32'd0);
        chk("idle_add_x_held", 32'(add_x), 32'd100);

        run_op(1, 16'hFFFF, 16'h0001, 1'b0);
        chk("sum_wrap", 32'(sum_out), 32'h0000);
        chk("cout_wrap", 32'(cout_out), 32'd1);
        run_op(1, 16'hFFFF, 16'hFFFF, 1'b1);
        chk("sum_max", 32'(sum_out), 32'hFFFF);
        chk("cout_max", 32'(cout_out), 32'd1);

        // slot 1 was served last, so slot 2 outranks it
        req = 4'b0110;
        wait_gnt(g);
        chk("rot_first", 32'(g), 32'b0100);
        wait_gnt(g);
        chk("rot_second", 32'(g), 32'b0010);
        wait_quiet();

        do_reset();
        hold = 4'b1111;
        req  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g);
            chk("rr_order", 32'(g), 32'(1 << (k % 4)));
        end
        hold = 4'b0000;
        req  = 4'b0000;
        wait_quiet();

        req[3] = 1'b1;
        wait_gnt(g);
        chk("slot3_gnt", 32'(g), 32'b1000);
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_op_count", 32'(op_count), 32'd0);
        run_op(3, 16'h1234, 16'h4321, 1'b1);
        chk("after_abort_sum", 32'(sum_out), 32'h5556);
        chk("after_abort_op_count", 32'(op_count), OPC_EN ? 32'd1 : 32'd0);

        repeat (40) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i]) begin
                    xs[i]   = 16'($urandom);
                    ys[i]   = 16'($urandom);
                    cins[i] = 1'($urandom_range(0, 1));
                end
            end
            req  = req | 4'($urandom_range(0, 15));
            hold = 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 6)) tick();
        end
        hold = 4'b0000;
        wait_quiet();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
